// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - bit-level I2C master for one 3-byte write (slave addr, sub addr, data)
module i2c_write_master #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oBUSY,
  output logic        oEND,
  output logic        oACK_ERR,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  // Quarter-bit length in system clocks
  localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("i2c_write_master: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_ACK,
    S_STOP,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    qidx_q, qidx_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   shreg_q, shreg_d;
  logic          ack_err_q, ack_err_d;
  logic          go_prev_q, go_prev_d;
  logic          busy_q, busy_d;
  logic          end_q, end_d;
  logic          scl_q, scl_d;
  logic          sda_low_q, sda_low_d;

  logic accept;
  logic in_phase;
  logic q_tick;
  logic phase_end;
  logic sda_in;

  assign sda_in    = I2C_SDAT;
  assign accept    = (state_q == S_IDLE) && iGO && !go_prev_q;
  assign in_phase  = (state_q == S_START) || (state_q == S_SHIFT) ||
                     (state_q == S_ACK) || (state_q == S_STOP);
  assign q_tick    = (qcnt_q == QMAX);
  assign phase_end = q_tick && (qidx_q == 2'd3);

  // State register; reset abandons any transfer without a STOP
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one phase is four quarters, DONE is a single cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: if (phase_end) state_d = S_SHIFT;
      S_SHIFT: if (phase_end && (bit_q == 3'd0)) state_d = S_ACK;
      S_ACK:   if (phase_end) state_d = (byte_q == 2'd2) ? S_STOP : S_SHIFT;
      S_STOP:  if (phase_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, shift register, edge detect and ACK sampling
  always_comb begin
    go_prev_d = iGO;
    qcnt_d    = qcnt_q;
    qidx_d    = qidx_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shreg_d   = shreg_q;
    ack_err_d = ack_err_q;
    if (accept) begin
      qcnt_d    = '0;
      qidx_d    = 2'd0;
      bit_d     = 3'd7;
      byte_d    = 2'd0;
      shreg_d   = iDATA;
      ack_err_d = 1'b0;
    end else if (in_phase) begin
      if (q_tick) begin
        qcnt_d = '0;
        qidx_d = qidx_q + 2'd1;
      end else begin
        qcnt_d = qcnt_q + QW'(1);
      end
      // Slave must hold SDA low through the last clock of q2; anything else is a NACK
      if ((state_q == S_ACK) && (qidx_q == 2'd2) && q_tick && (sda_in !== 1'b0)) begin
        ack_err_d = 1'b1;
      end
      if ((state_q == S_SHIFT) && phase_end) begin
        bit_d   = bit_q - 3'd1;
        shreg_d = {shreg_q[22:0], 1'b0};
      end
      if ((state_q == S_ACK) && phase_end) begin
        byte_d = byte_q + 2'd1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      qcnt_q    <= '0;
      qidx_q    <= 2'd0;
      bit_q     <= 3'd7;
      byte_q    <= 2'd0;
      shreg_q   <= 24'd0;
      ack_err_q <= 1'b0;
      go_prev_q <= 1'b0;
    end else begin
      qcnt_q    <= qcnt_d;
      qidx_q    <= qidx_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shreg_q   <= shreg_d;
      ack_err_q <= ack_err_d;
      go_prev_q <= go_prev_d;
    end
  end

  // Output decode from the next state so registered pins line up with the phase they belong to
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    end_d     = (state_d == S_DONE);
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state_d)
      S_START: sda_low_d = qidx_d[1];
      S_SHIFT: begin
        scl_d     = qidx_d[1];
        sda_low_d = ~shreg_d[23];
      end
      S_ACK:   scl_d = qidx_d[1];
      S_STOP: begin
        scl_d     = (qidx_d != 2'd0);
        sda_low_d = ~qidx_d[1];
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      end_q     <= end_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign oBUSY    = busy_q;
  assign oEND     = end_q;
  assign oACK_ERR = ack_err_q;
  assign I2C_SCLK = scl_q;
  // Open drain: pull low or release, never drive high
  assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_master.sv
// tb/tb_i2c_write_master.sv - scoreboard bench for i2c_write_master with bus decoder and slave model
module tb_i2c_write_master;

  localparam int CLK_FREQ = 400;
  localparam int I2C_FREQ = 25;
  localparam int DIV      = CLK_FREQ / (4 * I2C_FREQ);
  localparam int N_QUART  = 4 + 27 * 4 + 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [23:0] data = 24'd0;
  logic        busy, endp, ack_err, scl;
  wire         sda_bus;
  logic        slave_pull = 1'b0;
  logic [2:0]  nack_mask = 3'd0;

  pullup (sda_bus);
  assign sda_bus = slave_pull ? 1'b0 : 1'bz;

  i2c_write_master #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
    .iCLK(clk), .iRST(rst), .iDATA(data), .iGO(go),
    .oBUSY(busy), .oEND(endp), .oACK_ERR(ack_err),
    .I2C_SCLK(scl), .I2C_SDAT(sda_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [23:0] bytes;
    logic [2:0]  nack;
    int          start_cyc;
    int          end_cyc;
  } exp_t;
  exp_t exp_q[$];

  // Bus decoder, protocol checker and slave model
  bit          in_txn = 1'b0;
  int          nrise = 0, nfall = 0, len = 0, start_tmp = 0, k = 0;
  logic        bits [0:26];
  bit          pscl = 1'b1, psda = 1'b1, rst_prev = 1'b1;
  logic [23:0] dec_bytes = 24'd0;
  logic [2:0]  dec_acks = 3'd0;
  int          dec_start = 0;
  bit          dec_valid = 1'b0;
  logic        s_scl, s_sda;

  always @(negedge clk) begin
    s_scl = scl;
    s_sda = sda_bus;
    if (rst || rst_prev) begin
      in_txn     = 1'b0;
      slave_pull = 1'b0;
    end else begin
      if (s_scl && pscl && (s_sda != psda)) begin
        if (!s_sda) begin
          chk(!in_txn, "start_inside_transfer", in_txn, 0);
          in_txn = 1'b1; nrise = 0; nfall = 0; len = 0; start_tmp = cyc;
        end else begin
          chk(in_txn && (nrise == 28), "stop_position", nrise, 28);
          if (in_txn) begin
            for (int b = 0; b < 3; b++) begin
              for (int i = 0; i < 8; i++) dec_bytes[23 - 8 * b - i] = bits[9 * b + i];
              dec_acks[b] = bits[9 * b + 8];
            end
            dec_start = start_tmp;
            dec_valid = 1'b1;
          end
          in_txn = 1'b0;
        end
      end
      if (in_txn) begin
        if (s_scl && !pscl) begin
          chk(len == ((nrise == 27) ? DIV : 2 * DIV), "scl_low_width", len, (nrise == 27) ? DIV : 2 * DIV);
          if (nrise < 27) bits[nrise] = s_sda;
          nrise++;
          len = 1;
        end else if (!s_scl && pscl) begin
          if (nfall > 0) chk(len == 2 * DIV, "scl_high_width", len, 2 * DIV);
          k = nfall;
          nfall++;
          len = 1;
          slave_pull = (k < 27) && ((k % 9) == 8) && !nack_mask[k / 9];
        end else begin
          len++;
        end
      end
    end
    pscl = s_scl;
    psda = s_sda;
    rst_prev = rst;
  end

  // Scoreboard monitor: compares each oEND against the oldest expected transfer
  int   end_count = 0;
  bit   end_prev = 1'b0;
  exp_t e_mon;

  always @(negedge clk) begin
    if (end_prev) begin
      chk(!busy, "busy_after_end", busy, 0);
      chk(!endp, "end_one_cycle", endp, 0);
    end
    end_prev = 1'b0;
    if (!rst && endp) begin
      end_prev = 1'b1;
      end_count++;
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_end", 1, 0);
      end else begin
        e_mon = exp_q.pop_front();
        chk(cyc == e_mon.end_cyc, "end_cycle", cyc, e_mon.end_cyc);
        chk(busy, "busy_at_end", busy, 1);
        chk(ack_err == (|e_mon.nack), "ack_err_at_end", ack_err, |e_mon.nack);
        chk(dec_valid, "bus_transfer_seen", dec_valid, 1);
        chk(dec_bytes == e_mon.bytes, "bus_bytes", dec_bytes, e_mon.bytes);
        chk(dec_acks == e_mon.nack, "bus_ack_bits", dec_acks, e_mon.nack);
        chk(dec_start == e_mon.start_cyc, "start_cycle", dec_start, e_mon.start_cyc);
      end
      dec_valid = 1'b0;
    end
  end

  task automatic start_txn(input logic [23:0] d, input logic [2:0] nk);
    exp_t e;
    int   t;
    @(posedge clk); #1 go = 1'b0;
    @(posedge clk); #1 data = d; go = 1'b1; nack_mask = nk; t = cyc;
    e.bytes = d;
    e.nack = nk;
    e.start_cyc = t + 1 + 2 * DIV;
    e.end_cyc = t + 1 + N_QUART * DIV;
    exp_q.push_back(e);
    @(negedge clk);
    @(negedge clk);
    chk(busy, "busy_after_accept", busy, 1);
    chk(!ack_err, "ack_err_cleared_at_accept", ack_err, 0);
  endtask

  task automatic wait_end();
    int n0;
    n0 = end_count;
    for (int i = 0; i < N_QUART * DIV + 50 && end_count == n0; i++) @(negedge clk);
    chk(end_count != n0, "end_timeout", end_count - n0, 1);
  endtask

  task automatic check_idle(input string tag);
    chk(scl == 1'b1, {tag, "_scl"}, scl, 1);
    chk(sda_bus == 1'b1, {tag, "_sda"}, sda_bus, 1);
    chk(!busy, {tag, "_busy"}, busy, 0);
    chk(!endp, {tag, "_end"}, endp, 0);
    chk(!ack_err, {tag, "_ack_err"}, ack_err, 0);
  endtask

  logic [23:0] orig;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Nominal transfer
    start_txn(24'h341201, 3'b000);
    wait_end();

    // Second byte NACKed; flag holds until next accept
    start_txn(24'($urandom), 3'b010);
    wait_end();
    repeat (10) @(negedge clk);
    chk(ack_err, "ack_err_held", ack_err, 1);

    // iGO held across oEND must not restart
    start_txn(24'($urandom), 3'b000);
    wait_end();
    repeat (20) @(negedge clk);
    chk(!busy, "no_restart_while_go_held", busy, 0);

    // Mid-transfer iGO edge and iDATA change are ignored
    orig = 24'($urandom);
    start_txn(orig, 3'b000);
    repeat (100) @(posedge clk);
    #1 go = 1'b0; data = ~orig;
    @(posedge clk); #1 go = 1'b1; data = 24'($urandom);
    wait_end();

    // Reset during byte 2, then a fresh transfer
    start_txn(24'($urandom), 3'b000);
    repeat (170 + $urandom_range(0, 100)) @(posedge clk);
    #1 rst = 1'b1; go = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle("abort");
    start_txn(24'($urandom), 3'b000);
    wait_end();

    // Random data and random NACK patterns
    for (int n = 0; n < 4; n++) begin
      start_txn(24'($urandom), 3'($urandom_range(0, 7)));
      wait_end();
    end

    repeat (5) @(negedge clk);
    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
